mult_pipe_top: RTL



---
 rtl/mult_pipe_top.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mult_pipe_top.sv
// ---------------------------------------------------------------------------
// mult_pipe_top
//
// Elastic, pipelined multiplier. Each accepted operand pair is multiplied in
// unsigned or two's-complement mode. The product is truncated to N_OUT bits
// and carried through N_STAGES register stages. Both sides use a valid/ready
// handshake. Bubbles collapse, so a full stream moves one result per cycle.
//
// Optional feature macro: MULT_PIPE_SKID_EN
//   When defined, a 2-entry FIFO sits after the last stage. The outputs come
//   from the FIFO head. The FIFO adds one cycle of latency and two entries of
//   capacity, and it removes the combinational path from out_ready_i to
//   in_ready_o.
//
// Parameters:
//   N_IN      operand width
//   N_OUT     result width (1..2*N_IN)
//   N_STAGES  number of pipeline register stages (>= 1)
//
// Ports:
//   clk_ci       clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept the operand pair
//   signed_i     1 = two's-complement multiply, sampled with the operands
//   operand_a_i  multiplicand
//   operand_b_i  multiplier
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   result_o     product (N_OUT LSBs of the full product)
//   inflight_o   number of valid entries held (stages plus skid entries)
// ---------------------------------------------------------------------------
module mult_pipe_top #(
    parameter int N_IN     = 2,
    parameter int N_OUT    = 4,
    parameter int N_STAGES = 2
) (
    input  logic                              clk_ci,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic                              signed_i,
    input  logic [N_IN-1:0]                   operand_a_i,
    input  logic [N_IN-1:0]                   operand_b_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [N_OUT-1:0]                  result_o,
    output logic [$clog2(N_STAGES+3)-1:0]     inflight_o
);

    localparam int PW    = 2 * N_IN;
    localparam int CNT_W = $clog2(N_STAGES + 3);

    logic [PW-1:0]       ext_a;
    logic [PW-1:0]       ext_b;
    logic [N_OUT-1:0]    product;

    logic                in_fire;
    logic                out_fire;
    logic                last_ready;
    logic                chain_ready;

    logic [N_STAGES-1:0] stage_valid;
    logic [N_STAGES-1:0] stage_load;
    logic [N_STAGES-1:0] stage_move;
    logic [N_OUT-1:0]    stage_data [N_STAGES];

    logic [N_STAGES-1:0] feed_valid;
    logic [N_OUT-1:0]    feed_data  [N_STAGES];

    // Extend both operands to the full product width. The low 2*N_IN bits
    // of an unsigned multiply of the extended values are then correct for
    // both modes.
    always_comb begin
        if (signed_i) begin
            ext_a = {{N_IN{operand_a_i[N_IN-1]}}, operand_a_i};
            ext_b = {{N_IN{operand_b_i[N_IN-1]}}, operand_b_i};
        end else begin
            ext_a = {{N_IN{1'b0}}, operand_a_i};
            ext_b = {{N_IN{1'b0}}, operand_b_i};
        end
        product = N_OUT'(ext_a * ext_b);
    end

    // Ready ripples backwards from the output. A stage loads when it is
    // empty or when its content is leaving this cycle, so bubbles collapse.
    always_comb begin
        chain_ready = last_ready;
        stage_move  = '0;
        stage_load  = '0;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            stage_move[k] = stage_valid[k] && chain_ready;
            stage_load[k] = !stage_valid[k] || stage_move[k];
            chain_ready   = stage_load[k];
        end
    end

    assign in_ready_o = stage_load[0];
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    // The value offered to each stage: the new product for stage 1, and the
    // previous stage's content for every later stage.
    always_comb begin
        feed_valid[0] = in_fire;
        feed_data[0]  = product;
        for (int k = 1; k < N_STAGES; k++) begin
            feed_valid[k] = stage_valid[k-1];
            feed_data[k]  = stage_data[k-1];
        end
    end

    // On load, a stage's valid bit copies its feed. This clears the bit when
    // the stage drains with nothing arriving behind it. The data register
    // only captures real entries, so a held result never changes under a
    // bubble.
    always_ff @(posedge clk_ci or posedge rst_i) begin
        if (rst_i) begin
            stage_valid <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (stage_load[k]) begin
                    stage_valid[k] <= feed_valid[k];
                    if (feed_valid[k]) begin
                        stage_data[k] <= feed_data[k];
                    end
                end
            end
        end
    end

`ifdef MULT_PIPE_SKID_EN
    logic [N_OUT-1:0] fifo_data [2];
    logic             fifo_rd_ptr;
    logic             fifo_wr_ptr;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;

    // The last stage only looks at FIFO occupancy. This is what breaks the
    // combinational path from out_ready_i back to in_ready_o.
    assign fifo_full  = (fifo_count == 2'd2);
    assign last_ready = !fifo_full;
    assign fifo_push  = stage_move[N_STAGES-1];
    assign fifo_pop   = out_fire;

    assign out_valid_o = (fifo_count != 2'd0);
    assign result_o    = fifo_data[fifo_rd_ptr];

    // Two-entry FIFO with no bypass. A push and a pop in the same cycle
    // leave the count unchanged.
    always_ff @(posedge clk_ci or posedge rst_i) begin
        if (rst_i) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_rd_ptr  <= 1'b0;
            fifo_wr_ptr  <= 1'b0;
            fifo_count   <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_data[fifo_wr_ptr] <= stage_data[N_STAGES-1];
                fifo_wr_ptr            <= ~fifo_wr_ptr;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + 2'd1;
            end else if (fifo_pop && !fifo_push) begin
                fifo_count <= fifo_count - 2'd1;
            end
        end
    end
`else
    // Without the skid FIFO, the last stage drives the outputs directly and
    // advances on downstream ready.
    assign last_ready  = out_ready_i;
    assign out_valid_o = stage_valid[N_STAGES-1];
    assign result_o    = stage_data[N_STAGES-1];
`endif

    // Occupancy counter. It moves only when exactly one side transfers.
    always_ff @(posedge clk_ci or posedge rst_i) begin
        if (rst_i) begin
            inflight_o <= '0;
        end else if (in_fire && !out_fire) begin
            inflight_o <= inflight_o + CNT_W'(1);
        end else if (out_fire && !in_fire) begin
            inflight_o <= inflight_o - CNT_W'(1);
        end
    end

endmodule
